// File: rtl/trace_event_buffer_if.sv
// Consumer-side stream of the trace event buffer: head entry plus the
// valid/ready handshake. The buffer drives it through the master modport.
// The consumer uses the slave modport.
interface trace_event_buffer_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32,
   parameter int TS_W   = 16
);
   logic              out_valid;
   logic              out_ready;
   logic [1:0]        out_kind;
   logic [ADDR_W-1:0] out_tag;
   logic [DATA_W-1:0] out_data;
   logic [TS_W-1:0]   out_ts;

   modport master (
      output out_valid, out_kind, out_tag, out_data, out_ts,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_kind, out_tag, out_data, out_ts,
      output out_ready
   );
endinterface

// File: rtl/trace_event_buffer.sv
// Commit-trace capture: snoops the register-file write port and the
// data-memory port. Each event is timestamped and queued in a show-ahead
// FIFO that accepts up to two pushes per cycle.
// Optional macro TRACE_ADDR_FILTER_EN adds the flt_lo/flt_hi address window
// for memory events.
module trace_event_buffer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int REG_W  = 5,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 16,
   parameter int DROP_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       RegWriteSignal,
   input  logic [REG_W-1:0]           RegNum,
   input  logic [DATA_W-1:0]          RegData,
   input  logic                       WR,
   input  logic                       RD,
   input  logic [ADDR_W-1:0]          Address,
   input  logic [DATA_W-1:0]          WRData,
   input  logic [DATA_W-1:0]          RDData,
   input  logic [2:0]                 en_mask,
   input  logic                       clear,
`ifdef TRACE_ADDR_FILTER_EN
   input  logic [ADDR_W-1:0]          flt_lo,
   input  logic [ADDR_W-1:0]          flt_hi,
`endif
   trace_event_buffer_if.master       trace,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [DROP_W-1:0]          drop_cnt
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int ENT_W = 2 + ADDR_W + DATA_W + TS_W;

   logic [ENT_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic [DROP_W-1:0] drop_reg, drop_next;
   logic [TS_W-1:0]   ts_reg;

   logic              reg_ev, mem_ev, addr_ok, pop;
   logic              acc_reg, acc_mem, wr0_en, wr1_en;
   logic [1:0]        mem_kind, n_push, n_drop;
   logic [DATA_W-1:0] mem_dat;
   logic [CNT_W:0]    free;
   logic [ENT_W-1:0]  reg_ent, mem_ent, slot0, slot1, head;
   logic [PTR_W-1:0]  wr_ptr_plus1;
   logic [DEPTH-1:0]  we0, we1;
   logic [DROP_W+1:0] drop_sum;

   // Optional address window; an empty window (lo > hi) rejects everything.
`ifdef TRACE_ADDR_FILTER_EN
   assign addr_ok = (Address >= flt_lo) && (Address <= flt_hi);
`else
   assign addr_ok = 1'b1;
`endif

   // Classify this cycle's strobes into at most one reg and one mem event.
   always_comb begin
      mem_ev   = 1'b0;
      mem_kind = 2'd0;
      mem_dat  = WRData;
      case ({WR, RD})
         2'b10: begin mem_kind = 2'd1; mem_ev = en_mask[1]; end
         2'b01: begin mem_kind = 2'd2; mem_ev = en_mask[2]; mem_dat = RDData; end
         2'b11: begin mem_kind = 2'd3; mem_ev = en_mask[2]; end
         default: ;
      endcase
      mem_ev = mem_ev & addr_ok;
      reg_ev = en_mask[0] & RegWriteSignal & (RegNum != '0);
   end

   assign reg_ent = {2'd0, ADDR_W'(RegNum), RegData, ts_reg};
   assign mem_ent = {mem_kind, Address, mem_dat, ts_reg};

   assign trace.out_valid = (count_reg != '0);
   assign pop             = trace.out_valid & trace.out_ready;

   // Admission: a same-cycle pop frees a slot; the reg event claims space first.
   always_comb begin
      free    = (CNT_W+1)'(DEPTH) - {1'b0, count_reg} + {{CNT_W{1'b0}}, pop};
      acc_reg = reg_ev && (free != '0);
      acc_mem = mem_ev && (acc_reg ? (free >= (CNT_W+1)'(2)) : (free != '0));
      n_push  = {1'b0, acc_reg} + {1'b0, acc_mem};
      n_drop  = ({1'b0, reg_ev} + {1'b0, mem_ev}) - n_push;
      wr0_en  = acc_reg | acc_mem;
      wr1_en  = acc_reg & acc_mem;
      slot0   = acc_reg ? reg_ent : mem_ent;
      slot1   = mem_ent;
   end

   assign wr_ptr_plus1 = wr_ptr_reg + PTR_W'(1);

   // Per-slot write-enable decode for the two write ports.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         assign we0[gi] = wr0_en && (wr_ptr_reg == PTR_W'(gi));
         assign we1[gi] = wr1_en && (wr_ptr_plus1 == PTR_W'(gi));
      end
   endgenerate

   // Entry storage; port 0 and port 1 never target the same slot.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (we0[i])
            mem[i] <= slot0;
         else if (we1[i])
            mem[i] <= slot1;
      end
   end

   // Next pointer/count/drop values; clear flushes and discards this cycle's events.
   always_comb begin
      drop_sum    = {2'b00, drop_reg} + (DROP_W+2)'(n_drop);
      drop_next   = (drop_sum > {2'b00, {DROP_W{1'b1}}}) ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
      wr_ptr_next = wr_ptr_reg + PTR_W'(n_push);
      rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
      count_next  = count_reg + CNT_W'(n_push) - CNT_W'(pop);
      if (clear) begin
         drop_next   = '0;
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end
   end

   // State registers; the timestamp keeps running through clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         drop_reg   <= '0;
         ts_reg     <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         drop_reg   <= drop_next;
         ts_reg     <= ts_reg + TS_W'(1);
      end
   end

   // Show-ahead head; fields read as zero whenever the FIFO is empty.
   assign head           = mem[rd_ptr_reg];
   assign trace.out_kind = trace.out_valid ? head[ENT_W-1 -: 2] : '0;
   assign trace.out_tag  = trace.out_valid ? head[ENT_W-3 -: ADDR_W] : '0;
   assign trace.out_data = trace.out_valid ? head[TS_W +: DATA_W] : '0;
   assign trace.out_ts   = trace.out_valid ? head[TS_W-1:0] : '0;

   assign count    = count_reg;
   assign drop_cnt = drop_reg;
endmodule

// File: doc/trace_event_buffer.md
Name: trace_event_buffer

Overview:
- Synthesizable commit-trace capture block for the RISC-V core.
- Snoops the register-file write port and the data-memory port every cycle, timestamps each event, and queues it in a parametrised FIFO.
- A downstream consumer (UART dumper, bench, debug port) drains the FIFO with a valid/ready handshake.
- Generalises pure simulation $display logging into hardware: selectable event classes, a drop counter, and simultaneous dual-event capture.

Parameters:
- DATA_W, 32, width of register and memory data.
- ADDR_W, 9, data-memory word-address width.
- REG_W, 5, register index width.
- DEPTH, 16, FIFO entries; power of two, at least 4.
- TS_W, 16, timestamp counter width.
- DROP_W, 8, drop counter width.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- RegWriteSignal  in  1  register write strobe.
- RegNum  in  REG_W  register written.
- RegData  in  DATA_W  register write value.
- WR  in  1  memory write strobe.
- RD  in  1  memory read strobe.
- Address  in  ADDR_W  memory address.
- WRData  in  DATA_W  memory write data.
- RDData  in  DATA_W  memory read data.
- en_mask  in  3  capture enables: bit0 reg write, bit1 mem write, bit2 mem read/conflict.
- clear  in  1  synchronous flush of FIFO and drop counter (timestamp keeps running).
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_kind  out  2  0 reg write, 1 mem write, 2 mem read, 3 conflict (WR and RD both high).
- out_tag  out  ADDR_W  RegNum zero-extended, or Address.
- out_data  out  DATA_W  captured value.
- out_ts  out  TS_W  timestamp of the capture cycle.
- count  out  $clog2(DEPTH+1)  occupied entries.
- drop_cnt  out  DROP_W  events lost to full FIFO; saturating.

Behaviour:
- Reset: every output is 0 (out_valid=0, count=0, drop_cnt=0, out_kind/out_tag/out_data/out_ts=0). Timestamp counter is 0. FIFO pointers are 0.
- Reset mid-operation: all queued entries are discarded; no partial pop.

Timestamp:
- TS_W counter increments every cycle rst is low.
- Wraps to 0 after all-ones.
- An event carries the counter value of the cycle in which its strobe is sampled.

Event generation (per cycle, each gated by en_mask):
- Reg event: RegWriteSignal=1, RegNum≠0; writes to x0 are ignored. Data is RegData.
- Mem event: WR=1, RD=0 gives kind 1 with WRData. RD=1, WR=0 gives kind 2 with RDData. WR=RD=1 gives kind 3 with WRData. WR=RD=0 gives no mem event.
- Kinds 2 and 3 are both gated by en_mask[2].

Push:
- Up to 2 pushes per cycle.
- When both events occur in one cycle, the reg event is ordered before the mem event.
- Free = DEPTH - count + pop, where pop = out_valid & out_ready. A same-cycle pop frees a slot.
- If needed pushes > free, the reg event is kept first, then the mem event if space remains.
- Each unaccepted event increments drop_cnt by 1, saturating at all-ones.

Pop and latency:
- An event sampled in cycle N appears at the head with out_valid=1 in cycle N+1 at the earliest (show-ahead FIFO).
- Head outputs are stable while out_valid=1 and out_ready=0.

Count:
- count' = count + pushes - pop, range 0..DEPTH.
- Pointers wrap modulo DEPTH.

Clear:
- Next cycle: count=0, out_valid=0, drop_cnt=0.
- Events in the clear cycle are discarded and not counted as drops.
- clear has priority over push and pop; rst has priority over clear.

Optional Feature:
- Macro: TRACE_ADDR_FILTER_EN.
- Defined: adds inputs flt_lo and flt_hi (each ADDR_W). Mem events (kinds 1–3) are captured only when flt_lo ≤ Address ≤ flt_hi (unsigned). Filtered events are silently discarded and never counted in drop_cnt. If flt_lo > flt_hi, no mem events are captured.
- Undefined: ports are absent; all mem events are subject only to en_mask.

Test Plan:
- Reset, then RegWriteSignal=1, RegNum=5, RegData=0x0000002A at ts=3 -> next cycle out_valid=1, kind=0, tag=5, data=0x2A, ts=3.
- Same cycle: reg write x7=0xFFFFFFFF and WR=1, Address=12, WRData=0x10 -> two entries in order (kind0 tag7), then (kind1 tag12 data 0x10); count=2.
- out_ready=0, 17 single reg writes with DEPTH=16 -> count=16, drop_cnt=1. Then one cycle with a dual event plus pop -> reg event accepted, mem event dropped, drop_cnt=2.
- WR=1 and RD=1, Address=3, WRData=0xAB -> kind=3, data=0xAB. Same stimulus with en_mask=3'b011 -> nothing queued, drop_cnt unchanged.
- Write to x0 and RD with en_mask[2]=0 -> no entries. Then clear with 4 entries queued -> count=0, out_valid=0 next cycle. Assert rst while count=5 -> all outputs 0 next cycle.
- TRACE_ADDR_FILTER_EN, flt_lo=8, flt_hi=15: reads at addresses 7, 8, 15, 16 -> only 8 and 15 queued; drop_cnt=0.
